triangle_channel_control: RTL and testbench

//  Sequencing front end of the NES APU triangle channel; drives the step-enable input of the triangle waveform generator.

---
 rtl/apu_pkg.sv | 38 +++
 rtl/apu_length_counter.sv | 47 ++++
 rtl/triangle_channel_control.sv | 136 +++++++++++++
 tb/tb_triangle_channel_control.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apu_pkg
// Description : Shared APU definitions: register addresses, default widths and
//               the length-counter load table.
// Revision    : 1.0 - initial release
// ============================================================================
package apu_pkg;

   localparam int APU_TIMER_W = 11;
   localparam int APU_LIN_W   = 7;
   localparam int APU_LEN_W   = 8;

   // Low two address bits of the triangle register block ($4008-$400B)
   typedef enum logic [1:0] {
      TRI_ADDR_LINEAR   = 2'd0,
      TRI_ADDR_UNUSED   = 2'd1,
      TRI_ADDR_TIMER_LO = 2'd2,
      TRI_ADDR_TIMER_HI = 2'd3
   } tri_addr_e;

   function automatic logic [7:0] len_lookup(input logic [4:0] idx);
      logic [7:0] v;
      case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apu_length_counter.sv
`default_nettype none
// ============================================================================
// Module      : apu_length_counter
// Description : Channel length counter with load, halt, half-frame decrement
//               and channel-disable clear.
// Revision    : 1.0 - initial release
// ============================================================================
module apu_length_counter #(
   parameter int LEN_W = 8
) (
   input  logic             iClk,
   input  logic             iReset_n,
   input  logic             iEnable,
   input  logic             iLoad,
   input  logic [LEN_W-1:0] iLoadVal,
   input  logic             iHalt,
   input  logic             iHalfFrame,
   output logic             oActive
);

   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] count_d;

   // Disable overrides load, and load overrides a coincident decrement
   always_comb begin
      count_d = count_q;
      if (!iEnable) begin
         count_d = '0;
      end else if (iLoad) begin
         count_d = iLoadVal;
      end else if (iHalfFrame && !iHalt && (count_q != '0)) begin
         count_d = count_q - LEN_W'(1);
      end
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign oActive = (count_q != '0);

endmodule
`default_nettype wire

// File: rtl/triangle_channel_control.sv
`default_nettype none
// ============================================================================
// Module      : triangle_channel_control
// Description : NES APU triangle sequencing front end; produces the waveform
//               step enable. Option macro: TRI_ULTRASONIC_MUTE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module triangle_channel_control
   import apu_pkg::*;
#(
   parameter int TIMER_W = APU_TIMER_W,
   parameter int LIN_W   = APU_LIN_W,
   parameter int LEN_W   = APU_LEN_W
) (
   input  logic       iClk,
   input  logic       iReset_n,
   input  logic       iWrEn,
   input  logic [1:0] iAddr,
   input  logic [7:0] iWrData,
   input  logic       iChanEnable,
   input  logic       iTimerTick,
   input  logic       iQuarterFrame,
   input  logic       iHalfFrame,
   output logic       oStep,
   output logic       oLengthActive
);

   logic [TIMER_W-1:0] period_q, period_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [LIN_W-1:0]   linear_q, linear_d;
   logic [LIN_W-1:0]   lin_reload_q, lin_reload_d;
   logic               control_q, control_d;
   logic               reload_flag_q, reload_flag_d;
   logic               step_q, step_d;

   logic               w_expire;
   logic               w_len_active;
   logic               w_wr_lin;
   logic               w_wr_lo;
   logic               w_wr_hi;
   tri_addr_e          w_addr;

   assign w_addr   = tri_addr_e'(iAddr);
   assign w_wr_lin = iWrEn && (w_addr == TRI_ADDR_LINEAR);
   assign w_wr_lo  = iWrEn && (w_addr == TRI_ADDR_TIMER_LO);
   assign w_wr_hi  = iWrEn && (w_addr == TRI_ADDR_TIMER_HI);

   always_comb begin
      timer_d       = timer_q;
      w_expire      = 1'b0;
      period_d      = period_q;
      control_d     = control_q;
      lin_reload_d  = lin_reload_q;
      linear_d      = linear_q;
      reload_flag_d = reload_flag_q;
      step_d        = 1'b0;

      if (iTimerTick) begin
         if (timer_q == '0) begin
            timer_d  = period_q;
            w_expire = 1'b1;
         end else begin
            timer_d = timer_q - TIMER_W'(1);
         end
      end

      // Linear update sees the pre-write control, reload value and flag
      if (iQuarterFrame) begin
         if (reload_flag_q) begin
            linear_d = lin_reload_q;
         end else if (linear_q != '0) begin
            linear_d = linear_q - LIN_W'(1);
         end
         if (!control_q) begin
            reload_flag_d = 1'b0;
         end
      end

      if (w_wr_lin) begin
         control_d    = iWrData[7];
         lin_reload_d = LIN_W'(iWrData[6:0]);
      end
      if (w_wr_lo) begin
         period_d[7:0] = iWrData;
      end
      if (w_wr_hi) begin
         period_d[TIMER_W-1:8] = iWrData[TIMER_W-9:0];
         reload_flag_d         = 1'b1;
      end

      step_d = w_expire && (linear_q != '0) && w_len_active;
`ifdef TRI_ULTRASONIC_MUTE_EN
      if (period_q < TIMER_W'(2)) begin
         step_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         period_q      <= '0;
         timer_q       <= '0;
         linear_q      <= '0;
         lin_reload_q  <= '0;
         control_q     <= 1'b0;
         reload_flag_q <= 1'b0;
         step_q        <= 1'b0;
      end else begin
         period_q      <= period_d;
         timer_q       <= timer_d;
         linear_q      <= linear_d;
         lin_reload_q  <= lin_reload_d;
         control_q     <= control_d;
         reload_flag_q <= reload_flag_d;
         step_q        <= step_d;
      end
   end

   apu_length_counter #(
      .LEN_W (LEN_W)
   ) u_length (
      .iClk       (iClk),
      .iReset_n   (iReset_n),
      .iEnable    (iChanEnable),
      .iLoad      (w_wr_hi),
      .iLoadVal   (LEN_W'(len_lookup(iWrData[7:3]))),
      .iHalt      (control_q),
      .iHalfFrame (iHalfFrame),
      .oActive    (w_len_active)
   );

   assign oStep         = step_q;
   assign oLengthActive = w_len_active;

endmodule
`default_nettype wire

// File: tb/tb_triangle_channel_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_triangle_channel_control
// Description : Self-checking bench for triangle_channel_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_channel_control;

   logic       iClk = 1'b0;
   logic       iReset_n = 1'b0;
   logic       iWrEn = 1'b0;
   logic [1:0] iAddr = 2'd0;
   logic [7:0] iWrData = 8'd0;
   logic       iChanEnable = 1'b0;
   logic       iTimerTick = 1'b0;
   logic       iQuarterFrame = 1'b0;
   logic       iHalfFrame = 1'b0;
   logic       oStep;
   logic       oLengthActive;

   triangle_channel_control dut (
      .iClk          (iClk),
      .iReset_n      (iReset_n),
      .iWrEn         (iWrEn),
      .iAddr         (iAddr),
      .iWrData       (iWrData),
      .iChanEnable   (iChanEnable),
      .iTimerTick    (iTimerTick),
      .iQuarterFrame (iQuarterFrame),
      .iHalfFrame    (iHalfFrame),
      .oStep         (oStep),
      .oLengthActive (oLengthActive)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      bit step;
      bit active;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_steps  = 0;
   bit   r_en     = 1'b0;

   int len_tab[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                       12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

   int m_period, m_timer, m_lin, m_rval, m_len;
   bit m_ctrl, m_rflag;

   task automatic model_reset();
      m_period = 0; m_timer = 0; m_lin = 0; m_rval = 0; m_len = 0;
      m_ctrl = 1'b0; m_rflag = 1'b0;
   endtask

   // One clock of stimulus: model predicts, scoreboard holds the prediction,
   // DUT output is compared one edge later.
   task automatic drive(input bit wr, input bit [1:0] a, input bit [7:0] d,
                        input bit tk, input bit qf, input bit hf);
      exp_t e;
      bit   exp_step, hi, n_rflag;
      int   n_timer, n_lin, n_len;
      @(negedge iClk);
      iWrEn = wr; iAddr = a; iWrData = d; iChanEnable = r_en;
      iTimerTick = tk; iQuarterFrame = qf; iHalfFrame = hf;
      hi = wr && (a == 2'd3);
      exp_step = tk && (m_timer == 0) && (m_lin != 0) && (m_len != 0);
`ifdef TRI_ULTRASONIC_MUTE_EN
      if (m_period < 2) exp_step = 1'b0;
`endif
      n_timer = m_timer;
      if (tk) n_timer = (m_timer == 0) ? m_period : m_timer - 1;
      n_lin = m_lin;
      n_rflag = m_rflag;
      if (qf) begin
         if (m_rflag) n_lin = m_rval;
         else if (m_lin > 0) n_lin = m_lin - 1;
         if (!m_ctrl) n_rflag = 1'b0;
      end
      if (hi) n_rflag = 1'b1;
      if (!r_en) n_len = 0;
      else if (hi) n_len = len_tab[d[7:3]];
      else if (hf && !m_ctrl && m_len > 0) n_len = m_len - 1;
      else n_len = m_len;
      if (wr && a == 2'd0) begin
         m_ctrl = d[7];
         m_rval = int'(d[6:0]);
      end
      if (wr && a == 2'd2) m_period = (m_period & 32'h700) | int'(d);
      if (hi) m_period = (m_period & 32'hFF) | (int'(d[2:0]) << 8);
      m_timer = n_timer; m_lin = n_lin; m_rflag = n_rflag; m_len = n_len;
      e.step = exp_step;
      e.active = (m_len != 0);
      sb.push_back(e);
      @(posedge iClk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (oStep !== e.step || oLengthActive !== e.active) begin
         n_fail++;
         $display("FAIL scoreboard t=%0t: oStep=%b oLengthActive=%b, required oStep=%b oLengthActive=%b",
                  $time, oStep, oLengthActive, e.step, e.active);
      end
      if (oStep === 1'b1) n_steps++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      iReset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge iClk);
      #1;
      n_checks++;
      if (oStep !== 1'b0 || oLengthActive !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: oStep=%b oLengthActive=%b, required 0 0", oStep, oLengthActive);
      end
      @(negedge iClk);
      iReset_n = 1'b1;
   endtask

   task automatic test_basic_step();
      int s0;
      r_en = 1'b1;
      drive(1'b1, 2'd0, 8'h05, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (oLengthActive !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_length_loaded: oLengthActive=%b, required 1", oLengthActive);
      end
      s0 = n_steps;
      ticks(1);
      n_checks++;
      if (oStep !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_first_step_latency: oStep=%b, required 1", oStep);
      end
      ticks(15);
      n_checks++;
      if (n_steps - s0 != 4) begin
         n_fail++;
         $display("FAIL basic_step_rate: steps=%0d in 16 ticks, required 4", n_steps - s0);
      end
   endtask

   task automatic test_linear_expiry();
      int s0;
      for (int q = 0; q < 5; q++) begin
         drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
         ticks(4);
      end
      s0 = n_steps;
      ticks(8);
      n_checks++;
      if (n_steps - s0 != 0) begin
         n_fail++;
         $display("FAIL linear_expired_steps: steps=%0d, required 0", n_steps - s0);
      end
   endtask

   task automatic test_halt();
      int s0;
      drive(1'b1, 2'd0, 8'h90, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (oLengthActive !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_length_held: oLengthActive=%b, required 1", oLengthActive);
      end
      for (int i = 0; i < 20; i++) drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      s0 = n_steps;
      ticks(64);
      n_checks++;
      if (n_steps - s0 != 16) begin
         n_fail++;
         $display("FAIL halt_linear_reloaded_steps: steps=%0d in 64 ticks, required 16", n_steps - s0);
      end
   endtask

   task automatic test_length_expire();
      int s0;
      drive(1'b1, 2'd0, 8'h10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 8'h18, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (oLengthActive !== 1'b1) begin
         n_fail++;
         $display("FAIL len2_loaded: oLengthActive=%b, required 1", oLengthActive);
      end
      drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (oLengthActive !== 1'b1) begin
         n_fail++;
         $display("FAIL len2_after_one_hf: oLengthActive=%b, required 1", oLengthActive);
      end
      drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (oLengthActive !== 1'b0) begin
         n_fail++;
         $display("FAIL len2_after_two_hf: oLengthActive=%b, required 0", oLengthActive);
      end
      s0 = n_steps;
      ticks(8);
      n_checks++;
      if (n_steps - s0 != 0) begin
         n_fail++;
         $display("FAIL len_zero_steps: steps=%0d, required 0", n_steps - s0);
      end
      r_en = 1'b0;
      drive(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (oLengthActive !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_write_load: oLengthActive=%b, required 0", oLengthActive);
      end
      r_en = 1'b1;
   endtask

   task automatic test_write_halfframe();
      drive(1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (oLengthActive !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_hf_len_after9: oLengthActive=%b, required 1", oLengthActive);
      end
      drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (oLengthActive !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_hf_len_after10: oLengthActive=%b, required 0", oLengthActive);
      end
   endtask

   task automatic test_period1_and_reset();
      int s0, req;
      drive(1'b1, 2'd2, 8'h01, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      ticks(6);
      s0 = n_steps;
      ticks(16);
`ifdef TRI_ULTRASONIC_MUTE_EN
      req = 0;
`else
      req = 8;
`endif
      n_checks++;
      if (n_steps - s0 != req) begin
         n_fail++;
         $display("FAIL period1_step_rate: steps=%0d in 16 ticks, required %0d", n_steps - s0, req);
      end
      for (int i = 0; i < 4; i++) begin
         if (oStep === 1'b1) break;
         ticks(1);
      end
      iTimerTick = 1'b0;
      iReset_n = 1'b0;
      #1;
      n_checks++;
      if (oStep !== 1'b0 || oLengthActive !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: oStep=%b oLengthActive=%b, required 0 0", oStep, oLengthActive);
      end
      model_reset();
      sb.delete();
      @(negedge iClk);
      iReset_n = 1'b1;
      ticks(4);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_step();
      test_linear_expiry();
      test_halt();
      test_length_expire();
      test_write_halfframe();
      test_period1_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
